// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DCD/EXE/MEM/WB sequencer that decodes
// op/funct into datapath selects and drives per-state write strobes.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [1:0] EOp,
  output logic [2:0] ALUOp,
  output logic       ALUSrcB,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    DCD   = 3'd1,
    EXE   = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_J, C_JAL
  } cls_e;

  state_e     state_q, state_d;
  cls_e       cls;
  logic [1:0] npc_sel;
  logic       pc_wr, ir_wr, rf_wr, dm_wr, done_c;

  always_comb begin
    cls = C_NOP;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100001: cls = C_ADDU;
          6'b100011: cls = C_SUBU;
          6'b001000: cls = C_JR;
          default:   cls = C_NOP;
        endcase
      end
      6'b001101: cls = C_ORI;
      6'b100011: cls = C_LW;
      6'b101011: cls = C_SW;
      6'b000100: cls = C_BEQ;
      6'b001111: cls = C_LUI;
      6'b000010: cls = C_J;
      6'b000011: cls = C_JAL;
      default:   cls = C_NOP;
    endcase
  end

  // Selects depend only on the decoded instruction and are held across states.
  always_comb begin
    EOp     = 2'b00;
    ALUOp   = 3'b000;
    ALUSrcB = 1'b0;
    RegDst  = 2'b00;
    WDSel   = 2'b00;
    npc_sel = 2'b00;
    case (cls)
      C_ADDU: RegDst = 2'b01;
      C_SUBU: begin ALUOp = 3'b001; RegDst = 2'b01; end
      C_ORI:  begin ALUOp = 3'b010; ALUSrcB = 1'b1; EOp = 2'b01; end
      C_LUI:  begin ALUOp = 3'b010; ALUSrcB = 1'b1; EOp = 2'b10; end
      C_LW:   begin ALUSrcB = 1'b1; WDSel = 2'b01; end
      C_SW:   ALUSrcB = 1'b1;
      C_BEQ:  begin ALUOp = 3'b001; EOp = 2'b11; npc_sel = 2'b01; end
      C_J:    npc_sel = 2'b10;
      C_JAL:  begin npc_sel = 2'b10; RegDst = 2'b10; WDSel = 2'b10; end
      C_JR:   npc_sel = 2'b11;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    rf_wr   = 1'b0;
    dm_wr   = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      FETCH: begin
        pc_wr   = 1'b1;
        ir_wr   = 1'b1;
        state_d = DCD;
      end
      DCD: begin
        case (cls)
          C_J, C_JR: begin pc_wr = 1'b1; done_c = 1'b1; state_d = FETCH; end
          C_JAL: begin
            pc_wr   = 1'b1;
            rf_wr   = 1'b1;
            done_c  = 1'b1;
            state_d = FETCH;
          end
          C_NOP:   begin done_c = 1'b1; state_d = FETCH; end
          default: state_d = EXE;
        endcase
      end
      EXE: begin
        case (cls)
          C_BEQ:   begin pc_wr = zero; done_c = 1'b1; state_d = FETCH; end
          C_LW, C_SW: state_d = MEM;
          C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = WB;
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        case (cls)
          C_SW:    begin dm_wr = 1'b1; done_c = 1'b1; state_d = FETCH; end
          C_LW:    state_d = WB;
          default: state_d = FETCH;
        endcase
      end
      WB: begin
        rf_wr   = 1'b1;
        done_c  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset forces FETCH, whose strobes would otherwise be live; mask them here.
  assign PCWr  = pc_wr  & ~reset;
  assign IRWr  = ir_wr  & ~reset;
  assign RFWr  = rf_wr  & ~reset;
  assign DMWr  = dm_wr  & ~reset;
  assign done  = done_c & ~reset;
  assign NPCOp = (state_q == FETCH) ? 2'b00 : npc_sel;
  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: table-driven instruction-class model,
// per-cycle compare, directed test-plan sequences and randomized instructions.
module tb_mc_ctrl;

  logic       clk, reset, zero;
  logic [5:0] op, funct;
  logic       PCWr, IRWr, RFWr, DMWr, ALUSrcB, done;
  logic [1:0] EOp, RegDst, WDSel, NPCOp;
  logic [2:0] ALUOp, state;

  int errors = 0;
  int checks = 0;
  int m_state = 0;
  bit chk_en = 0;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr),
    .EOp(EOp), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
    .WDSel(WDSel), .NPCOp(NPCOp), .done(done), .state(state)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Class index: 0 NOP,1 ADDU,2 SUBU,3 JR,4 ORI,5 LW,6 SW,7 BEQ,8 LUI,9 J,10 JAL
  int op_t    [0:10] = '{0, 0, 0, 0, 13, 35, 43, 4, 15, 2, 3};
  int fn_t    [0:10] = '{0, 33, 35, 8, 0, 0, 0, 0, 0, 0, 0};
  int eop_t   [0:10] = '{0, 0, 0, 0, 1, 0, 0, 3, 2, 0, 0};
  int alu_t   [0:10] = '{0, 0, 1, 0, 2, 0, 0, 1, 2, 0, 0};
  int srcb_t  [0:10] = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0};
  int rdst_t  [0:10] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2};
  int wds_t   [0:10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
  int npc_t   [0:10] = '{0, 0, 0, 3, 0, 0, 0, 1, 0, 2, 2};
  int lat_t   [0:10] = '{2, 4, 4, 2, 4, 5, 4, 3, 4, 2, 2};
  bit exe_t   [0:10] = '{0, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0};
  bit mem_t   [0:10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
  bit wb_t    [0:10] = '{0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0};

  function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'd0) begin
      if (f == 6'd33) return 1;
      if (f == 6'd35) return 2;
      if (f == 6'd8)  return 3;
      return 0;
    end
    for (int k = 4; k <= 10; k++)
      if (int'(o) == op_t[k]) return k;
    return 0;
  endfunction

  // Path through the machine: 0,1 then optional 2 (exe), 3 (mem), 4 (wb).
  function automatic int last_of(input int c);
    if (wb_t[c])  return 4;
    if (mem_t[c]) return 3;
    if (exe_t[c]) return 2;
    return 1;
  endfunction

  function automatic int next_of(input int s, input int c);
    if (s == 0) return 1;
    if (s == last_of(c)) return 0;
    if (s == 1) return 2;
    if (s == 2) return mem_t[c] ? 3 : 4;
    return 4;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t m_state=%0d op=%0d funct=%0d)",
               name, act, exp, $time, m_state, op, funct);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_state = 0;
    else       m_state = next_of(m_state, cls_of(op, funct));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int c;
      bit e_pc, e_ir, e_rf, e_dm, e_done;
      c      = cls_of(op, funct);
      e_ir   = (m_state == 0);
      e_pc   = (m_state == 0) || (m_state == 1 && (c == 3 || c == 9 || c == 10))
               || (m_state == 2 && c == 7 && zero);
      e_rf   = (m_state == 4) || (m_state == 1 && c == 10);
      e_dm   = (m_state == 3 && c == 6);
      e_done = (m_state != 0) && (m_state == last_of(c));
      if (reset) begin
        e_pc = 0; e_ir = 0; e_rf = 0; e_dm = 0; e_done = 0;
      end
      chk("state", int'(state), m_state);
      chk("PCWr", int'(PCWr), int'(e_pc));
      chk("IRWr", int'(IRWr), int'(e_ir));
      chk("RFWr", int'(RFWr), int'(e_rf));
      chk("DMWr", int'(DMWr), int'(e_dm));
      chk("done", int'(done), int'(e_done));
      chk("EOp", int'(EOp), eop_t[c]);
      chk("ALUSrcB", int'(ALUSrcB), srcb_t[c]);
      if (c != 7 || m_state == 2) chk("ALUOp", int'(ALUOp), alu_t[c]);
      if (e_rf) begin
        chk("RegDst", int'(RegDst), rdst_t[c]);
        chk("WDSel", int'(WDSel), wds_t[c]);
      end
      if (!reset && m_state == 0) chk("NPCOp_fetch", int'(NPCOp), 0);
      else if ((e_pc && m_state != 0) || (c == 7 && m_state == 2))
        chk("NPCOp", int'(NPCOp), npc_t[c]);
    end
  end

  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z);
    int n;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (m_state != 1 && n < 10);
    if (m_state != 1) chk("wait_dcd_timeout", m_state, 1);
    op = o; funct = f; zero = z;
    if (o == 6'b000011) begin
      #1;
      chk("jal_PCWr", int'(PCWr), 1);
      chk("jal_RFWr", int'(RFWr), 1);
      chk("jal_RegDst", int'(RegDst), 2);
      chk("jal_WDSel", int'(WDSel), 2);
      chk("jal_NPCOp", int'(NPCOp), 2);
    end
    n = 1;
    do begin @(posedge clk); #1; n++; end while (m_state != 0 && n < 12);
    chk("latency", n, lat_t[cls_of(o, f)]);
  endtask

  initial begin
    int r;
    logic [5:0] ro, rf;
    op = 0; funct = 0; zero = 0; reset = 0;
    #1 reset = 1;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_PCWr", int'(PCWr), 0);
    chk("rst_IRWr", int'(IRWr), 0);
    chk("rst_done", int'(done), 0);
    #1 reset = 0;
    #1;
    chk("rel_PCWr", int'(PCWr), 1);
    chk("rel_IRWr", int'(IRWr), 1);

    issue(6'd0, 6'd0, 1'b0);
    issue(6'd0, 6'd0, 1'b0);
    issue(6'b100011, 6'd5, 1'b0);
    issue(6'b000100, 6'd0, 1'b1);
    issue(6'b000100, 6'd0, 1'b0);
    issue(6'b000011, 6'd0, 1'b0);
    issue(6'b001111, 6'd0, 1'b0);
    issue(6'b001101, 6'd0, 1'b0);
    issue(6'd0, 6'b100001, 1'b0);
    issue(6'd0, 6'b100011, 1'b0);
    issue(6'd0, 6'b001000, 1'b0);
    issue(6'b000010, 6'd0, 1'b0);
    issue(6'b101011, 6'd0, 1'b0);

    // sw abandoned by reset in EXE
    r = 0;
    do begin @(posedge clk); #1; r++; end while (m_state != 1 && r < 10);
    op = 6'b101011; funct = 6'd0;
    @(posedge clk); #1;
    chk("sw_in_exe", int'(state), 2);
    #1 reset = 1;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_DMWr", int'(DMWr), 0);
    chk("async_rst_PCWr", int'(PCWr), 0);
    @(posedge clk); #2 reset = 0;
    #1;
    chk("post_rst_PCWr", int'(PCWr), 1);
    chk("post_rst_state", int'(state), 0);
    issue(6'd0, 6'd0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 11);
      if (r < 11) begin
        ro = 6'(op_t[r]);
        rf = (r <= 3) ? 6'(fn_t[r]) : 6'($urandom);
      end else begin
        ro = 6'($urandom);
        rf = 6'($urandom);
      end
      issue(ro, rf, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
